b_g_cnt: RTL and testbench
==========================

B_G_CNT -- requirements
Module: b_g_cnt

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the counter and code width in bits (legal range 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port en, input, 1 bit: step request.
REQ-005 SHALL have port up, input, 1 bit: step direction, 1 = increment, 0 = decrement.
REQ-006 SHALL have port load, input, 1 bit: load request for B_in.
REQ-007 SHALL have port B_in, input, WIDTH bits: binary load value.
REQ-008 SHALL have port G, output, WIDTH bits: registered Gray code of the current count.
REQ-009 SHALL have port B, output, WIDTH bits: registered binary count.
REQ-010 SHALL have port G_valid, output, 1 bit: G, B and wrap hold a new, unconsumed code.
REQ-011 SHALL have port G_ready, input, 1 bit: consumer accepts the code this cycle.
REQ-012 SHALL have port wrap, output, 1 bit: the current code resulted from a boundary crossing; qualified by G_valid.
REQ-013 SHALL have port busy, output, 1 bit: combinational G_valid AND NOT G_ready.

Function
REQ-014 SHALL compute G = B XOR (B >> 1), bitwise, for every WIDTH bit; this is the exact inverse of the team's Gray-to-binary converter.
REQ-015 SHALL define accept = NOT G_valid OR G_ready; load and en SHALL be acted on only in cycles where accept = 1.
REQ-016 SHALL, when load = 1 and accept = 1, set B to B_in, G to gray(B_in), G_valid to 1 and wrap to 0 on the next edge; load SHALL take priority over en.
REQ-017 SHALL, when en = 1, load = 0 and accept = 1, set B to (B + 1) mod 2^WIDTH if up = 1, else to (B - 1) mod 2^WIDTH, update G to match, and set G_valid to 1; latency is one cycle from request to G.
REQ-018 SHALL set wrap to 1 on a step with up = 1 from B = 2^WIDTH - 1, or with up = 0 from B = 0; otherwise wrap SHALL be 0.
REQ-019 SHALL, when G_valid = 1, G_ready = 1 and no load or step is accepted, clear G_valid and wrap; G and B SHALL hold their values.
REQ-020 SHALL, while busy = 1, ignore load and en (requests are dropped, not queued), and hold G, B, wrap and G_valid stable.
REQ-021 SHALL produce successive step outputs whose G values differ in exactly one bit, including across the wrap boundary.
REQ-022 SHALL support back-to-back accepted steps: with G_ready = 1 and en = 1 held, G_valid SHALL stay 1 and the count SHALL advance every cycle.

Reset
REQ-023 SHALL, when rst = 1 at a clock edge, set B = 0, G = 0, G_valid = 0 and wrap = 0, overriding load, en and G_ready in that cycle.
REQ-024 SHALL, on reset asserted mid-stall (busy = 1), discard the pending code; after reset is released, the first accepted step SHALL be from B = 0.

Configuration
REQ-025 SHALL use the macro B_G_CNT_SAT_EN. When it is defined, a step at a boundary (up = 1 at all-ones, or up = 0 at zero) SHALL leave B and G unchanged, re-present the code with G_valid = 1, and set wrap = 1 to flag saturation. When it is not defined, the count SHALL wrap modulo 2^WIDTH as specified in REQ-017 and REQ-018.

Verification (WIDTH = 4)
REQ-026 SHALL cover reset: rst = 1 for 1 cycle with en = 1 and load = 1 -> G = 0000, B = 0000, G_valid = 0, wrap = 0.
REQ-027 SHALL cover an up sweep: G_ready = 1, up = 1, en = 1 for 16 cycles from reset -> G runs 0001, 0011, 0010, 0110, ..., 1000, then 0000 with wrap = 1 on the 16th step; each consecutive pair differs in 1 bit.
REQ-028 SHALL cover decrement and load: from B = 0, en = 1 with up = 0 -> B = 1111, G = 1000, wrap = 1; then load = 1 and en = 1 with B_in = 1010 -> B = 1010, G = 1111, wrap = 0.
REQ-029 SHALL cover backpressure: G_valid = 1 and G_ready = 0 while en = 1 for 3 cycles -> busy = 1 and G, B held; G_ready = 1 for 1 cycle -> exactly one step.
REQ-030 SHALL cover reset mid-stall: busy = 1, then rst = 1 -> G_valid = 0 and G = 0000 next cycle.
REQ-031 SHALL cover saturation: with B_G_CNT_SAT_EN defined, up = 1 step at B = 1111 -> G stays 1000, wrap = 1; without the macro, the same step gives G = 0000, wrap = 1.

Source files
------------

// File: rtl/b_g_cnt.sv
// b_g_cnt: up/down binary counter with a registered Gray-code output and a
//   single-entry valid/ready output stage.
// Latency: one cycle from an accepted load or step to the new G/B/wrap.
// Backpressure: while G_valid is high and G_ready is low (busy), load and en
//   are dropped, not queued, and all outputs hold.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   en, up            - step request and direction (1 = increment)
//   load, B_in        - load request and binary load value (load beats en)
//   G, B              - registered Gray code and binary count
//   G_valid, G_ready  - output handshake
//   wrap              - current code came from a boundary crossing
//   busy              - G_valid & ~G_ready (combinational)
//
// Optional feature: define B_G_CNT_SAT_EN to make the counter saturate at
// the boundaries instead of wrapping; wrap then flags the saturated step.

module b_g_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] B_in,
  output logic [WIDTH-1:0] G,
  output logic [WIDTH-1:0] B,
  output logic             G_valid,
  input  logic             G_ready,
  output logic             wrap,
  output logic             busy
);

  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic             vld_q, vld_d;
  logic             wrap_q, wrap_d;

  logic             accept;
  logic             at_bound;
  logic [WIDTH-1:0] b_step;

  // The output slot can take a new code when it is empty or being drained.
  assign accept = ~vld_q | G_ready;

  // Boundary for the requested direction: all-ones going up, zero going down.
  assign at_bound = up ? (&b_q) : ~(|b_q);
  assign b_step   = up ? (b_q + WIDTH'(1)) : (b_q - WIDTH'(1));

  always_comb begin
    b_d    = b_q;
    vld_d  = vld_q;
    wrap_d = wrap_q;

    if (accept) begin
      if (load) begin
        b_d    = B_in;
        vld_d  = 1'b1;
        wrap_d = 1'b0;
      end else if (en) begin
`ifdef B_G_CNT_SAT_EN
        // Saturate: the boundary code is re-presented unchanged.
        b_d    = at_bound ? b_q : b_step;
`else
        b_d    = b_step;
`endif
        vld_d  = 1'b1;
        wrap_d = at_bound;
      end else if (vld_q) begin
        // Consumed with nothing new behind it: empty the slot, keep the count.
        vld_d  = 1'b0;
        wrap_d = 1'b0;
      end
    end

    // Gray code is derived from the next binary value so G and B move together.
    g_d = b_d ^ (b_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_q    <= '0;
      g_q    <= '0;
      vld_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      b_q    <= b_d;
      g_q    <= g_d;
      vld_q  <= vld_d;
      wrap_q <= wrap_d;
    end
  end

  assign B       = b_q;
  assign G       = g_q;
  assign G_valid = vld_q;
  assign wrap    = wrap_q;
  assign busy    = vld_q & ~G_ready;

endmodule

// File: tb/tb_b_g_cnt.sv
// tb_b_g_cnt: directed, table-driven bench for b_g_cnt at WIDTH = 4.
// Each record drives one cycle of inputs and lists the outputs expected
// one rising edge later; busy is expected as exp_vld & ~G_ready.

module tb_b_g_cnt;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, en, up, load, G_ready;
  logic [W-1:0] B_in;
  logic [W-1:0] G, B;
  logic         G_valid, wrap, busy;

  int checks   = 0;
  int failures = 0;

  b_g_cnt #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .up      (up),
    .load    (load),
    .B_in    (B_in),
    .G       (G),
    .B       (B),
    .G_valid (G_valid),
    .G_ready (G_ready),
    .wrap    (wrap),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           r, e, u, l;
    logic [W-1:0] bi;
    bit           gr;
    logic [W-1:0] eb, eg;
    bit           ev, ew;
    bit           one_bit;   // G must differ from the previous G in one bit
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit e, bit u, bit l, logic [W-1:0] bi,
                              bit gr, logic [W-1:0] eb, logic [W-1:0] eg,
                              bit ev, bit ew, bit ob);
    vec_t v;
    v.r = r; v.e = e; v.u = u; v.l = l; v.bi = bi; v.gr = gr;
    v.eb = eb; v.eg = eg; v.ev = ev; v.ew = ew; v.one_bit = ob;
    return v;
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL vec%0d %s: got %0h expected %0h", idx, name, act, exp);
    end
  endtask

  initial begin
    logic [W-1:0] prev_g;
    logic [W-1:0] sweep_g[16];
    logic [W-1:0] sweep_b[16];

    // Up sweep from zero: hand-listed binary and Gray values after steps 1..16.
    sweep_b = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000,
                4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b0000};
    sweep_g = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

    //               r  e  u  l  B_in     rdy B        G        v  w  1bit
    // Reset overrides en and load.
    vecs.push_back(mk(1, 1, 1, 1, 4'b1010, 1, 4'b0000, 4'b0000, 0, 0, 0));
    // Up sweep, wrap flagged only on the 16th step.
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 1, sweep_b[i], sweep_g[i], 1, (i == 15), 1));
    // Decrement from zero wraps to all-ones.
    vecs.push_back(mk(0, 1, 0, 0, 4'b0000, 1, 4'b1111, 4'b1000, 1, 1, 1));
    // Load beats en and clears wrap.
    vecs.push_back(mk(0, 1, 0, 1, 4'b1010, 1, 4'b1010, 4'b1111, 1, 0, 0));
    // Idle with ready: slot drains, count holds.
    vecs.push_back(mk(0, 0, 0, 0, 4'b0000, 1, 4'b1010, 4'b1111, 0, 0, 0));
    // Backpressure: step into empty slot, then three stalled cycles.
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 0, 4'b1011, 4'b1110, 1, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 0, 4'b1011, 4'b1110, 1, 0, 0));
    // One cycle of ready gives exactly one step, then stalls again.
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 1, 4'b1100, 4'b1010, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 0, 4'b1100, 4'b1010, 1, 0, 0));
    // Reset mid-stall discards the pending code.
    vecs.push_back(mk(1, 1, 1, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0));
    // First step after reset starts from zero.
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 0, 4'b0001, 4'b0001, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4'b0000, 1, 4'b0001, 4'b0001, 0, 0, 0));
    // Load into empty slot, then a load while busy is dropped.
    vecs.push_back(mk(0, 0, 0, 1, 4'b0101, 0, 4'b0101, 4'b0111, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 4'b0011, 0, 4'b0101, 4'b0111, 1, 0, 0));
    // Plain decrement without wrap.
    vecs.push_back(mk(0, 1, 0, 0, 4'b0000, 1, 4'b0100, 4'b0110, 1, 0, 0));
    // Boundary steps: all-ones going up, zero going down.
    vecs.push_back(mk(0, 0, 0, 1, 4'b1111, 1, 4'b1111, 4'b1000, 1, 0, 0));
`ifdef B_G_CNT_SAT_EN
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 1, 4'b1111, 4'b1000, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 4'b0000, 1, 4'b0000, 4'b0000, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4'b0000, 1, 4'b0000, 4'b0000, 1, 1, 0));
`else
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 1, 4'b0000, 4'b0000, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 4'b0000, 1, 4'b0000, 4'b0000, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4'b0000, 1, 4'b1111, 4'b1000, 1, 1, 1));
`endif
    // Drain with ready after a wrap clears wrap as well as valid.
    vecs.push_back(mk(0, 0, 1, 0, 4'b0000, 1,
`ifdef B_G_CNT_SAT_EN
                      4'b0000, 4'b0000,
`else
                      4'b1111, 4'b1000,
`endif
                      0, 0, 0));

    rst = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; G_ready = 1'b0; B_in = '0;
    prev_g = '0;

    foreach (vecs[i]) begin
      @(negedge clk);
      rst     = vecs[i].r;
      en      = vecs[i].e;
      up      = vecs[i].u;
      load    = vecs[i].l;
      B_in    = vecs[i].bi;
      G_ready = vecs[i].gr;
      @(posedge clk);
      #1;
      check("B",       i, 32'(B),       32'(vecs[i].eb));
      check("G",       i, 32'(G),       32'(vecs[i].eg));
      check("G_valid", i, 32'(G_valid), 32'(vecs[i].ev));
      check("wrap",    i, 32'(wrap),    32'(vecs[i].ew));
      check("busy",    i, 32'(busy),    32'(vecs[i].ev & ~vecs[i].gr));
      if (vecs[i].one_bit)
        check("gray_1bit", i, 32'($countones(G ^ prev_g)), 32'd1);
      prev_g = G;
    end

    // Back-to-back stepping: valid stays high and the count advances each cycle.
    @(negedge clk);
    rst = 1'b1; en = 1'b0; load = 1'b0; G_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("b2b_B",     100 + i, 32'(B),       32'(i + 1));
      check("b2b_valid", 100 + i, 32'(G_valid), 32'd1);
    end
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
